// File: rtl/alu_result_skid_pkg.sv
// Shared constants for the ALU result output stage: default datapath widths and
// the skid-buffer state encoding (state value doubles as the occupancy count).
package alu_result_skid_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_TAG_W = 3;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   typedef enum logic [1:0] {
      StEmpty = ST_EMPTY,
      StOne   = ST_ONE,
      StFull  = ST_FULL
   } state_e;

endpackage

// File: rtl/alu_result_skid_if.sv
// Valid/ready bundle between the ALU, the result skid stage and MEM/writeback.
// slave is the skid stage's view; master is the view of whatever surrounds it.
interface alu_result_skid_if
   import alu_result_skid_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned TAG_W = DEF_TAG_W
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_zero;
   logic             out_neg;

   modport master (
      output in_valid, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_zero, out_neg
   );

   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_zero, out_neg
   );

endinterface

// File: rtl/alu_result_skid_flag_gen.sv
// Combinational zero/negative flag derivation for an ALU result.
module alu_flag_gen #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] data,
   output logic             zero,
   output logic             neg
);

   assign zero = (data == '0);
   assign neg  = data[WIDTH-1];

endmodule

// File: rtl/alu_result_skid.sv
// Registered ALU result stage: 2-entry skid buffer (main + skid) with flags captured at
// input time, so in_ready is a pure flop and the ready path back into the ALU is cut.
module alu_result_skid
   import alu_result_skid_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned TAG_W = DEF_TAG_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   alu_result_skid_if.slave   bus,
   output logic [1:0]         occupancy
);

   state_e           state_q;
   logic             in_ready_q;

   logic [WIDTH-1:0] main_data_q;
   logic [TAG_W-1:0] main_tag_q;
   logic             main_zero_q;
   logic             main_neg_q;

   logic [WIDTH-1:0] skid_data_q;
   logic [TAG_W-1:0] skid_tag_q;
   logic             skid_zero_q;
   logic             skid_neg_q;

   logic             in_zero;
   logic             in_neg;
   logic             out_valid;
   logic             in_fire;
   logic             out_fire;

   alu_flag_gen #(
      .WIDTH (WIDTH)
   ) u_flag_gen (
      .data (bus.in_data),
      .zero (in_zero),
      .neg  (in_neg)
   );

   assign out_valid = (state_q != StEmpty);
   assign in_fire   = bus.in_valid & in_ready_q;
   assign out_fire  = out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StEmpty;
         in_ready_q  <= 1'b1;
         main_data_q <= '0;
         main_tag_q  <= '0;
         main_zero_q <= 1'b0;
         main_neg_q  <= 1'b0;
         skid_data_q <= '0;
         skid_tag_q  <= '0;
         skid_zero_q <= 1'b0;
         skid_neg_q  <= 1'b0;
      end else if (flush) begin
         // Squash only clears occupancy; stale data in the entries is harmless.
         state_q    <= StEmpty;
         in_ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_fire) begin
                  main_data_q <= bus.in_data;
                  main_tag_q  <= bus.in_tag;
                  main_zero_q <= in_zero;
                  main_neg_q  <= in_neg;
                  state_q     <= StOne;
               end
            end
            StOne: begin
               if (in_fire && out_fire) begin
                  main_data_q <= bus.in_data;
                  main_tag_q  <= bus.in_tag;
                  main_zero_q <= in_zero;
                  main_neg_q  <= in_neg;
               end else if (in_fire) begin
                  skid_data_q <= bus.in_data;
                  skid_tag_q  <= bus.in_tag;
                  skid_zero_q <= in_zero;
                  skid_neg_q  <= in_neg;
                  state_q     <= StFull;
                  in_ready_q  <= 1'b0;
               end else if (out_fire) begin
                  state_q <= StEmpty;
               end
            end
            StFull: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  main_data_q <= skid_data_q;
                  main_tag_q  <= skid_tag_q;
                  main_zero_q <= skid_zero_q;
                  main_neg_q  <= skid_neg_q;
                  state_q     <= StOne;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q    <= StEmpty;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = main_data_q;
   assign bus.out_tag   = main_tag_q;
   assign bus.out_zero  = main_zero_q;
   assign bus.out_neg   = main_neg_q;
   assign occupancy     = state_q;

endmodule

// File: tb/tb_alu_result_skid.sv
// Bench for alu_result_skid: queue model of a 2-deep FIFO checked every cycle, plus
// directed scenarios with literal expectations.
module tb_alu_result_skid;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] occupancy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_exit   = 0;

   alu_result_skid_if #(.WIDTH(16), .TAG_W(3)) ifc ();

   alu_result_skid #(
      .WIDTH (16),
      .TAG_W (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .bus       (ifc.slave),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] d;
      logic [2:0]  t;
   } ent_t;

   ent_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: a FIFO of capacity 2; it accepts whenever it holds fewer than two entries.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else if (ifc.in_valid && q.size() < 2) begin
         if (ifc.out_ready && q.size() > 0) void'(q.pop_front());
         q.push_back('{d: ifc.in_data, t: ifc.in_tag});
      end else if (ifc.out_ready && q.size() > 0) begin
         void'(q.pop_front());
      end
   end

   logic        prev_stall = 1'b0;
   logic [15:0] prev_d     = '0;
   logic [2:0]  prev_t     = '0;

   always @(negedge clk) begin
      chk("out_valid", 32'(ifc.out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(ifc.in_ready), 32'(q.size() < 2));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      if (q.size() > 0) begin
         chk("out_data", 32'(ifc.out_data), 32'(q[0].d));
         chk("out_tag", 32'(ifc.out_tag), 32'(q[0].t));
         chk("out_zero", 32'(ifc.out_zero), 32'(q[0].d == 16'h0000));
         chk("out_neg", 32'(ifc.out_neg), 32'(q[0].d[15]));
      end
      if (prev_stall && ifc.out_valid) begin
         chk("stall_data", 32'(ifc.out_data), 32'(prev_d));
         chk("stall_tag", 32'(ifc.out_tag), 32'(prev_t));
      end
      prev_stall <= ifc.out_valid && !ifc.out_ready && !flush && rst_n;
      prev_d     <= ifc.out_data;
      prev_t     <= ifc.out_tag;
      if (ifc.out_valid && ifc.out_ready && !flush && rst_n) n_exit <= n_exit + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   e0;
      logic acc;

      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.in_tag    = '0;
      ifc.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      chk("rst_out_data", 32'(ifc.out_data), 32'd0);
      chk("rst_out_tag", 32'(ifc.out_tag), 32'd0);
      chk("rst_flags", 32'({ifc.out_zero, ifc.out_neg}), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);

      // Single pass of a zero result
      ifc.in_valid = 1'b1; ifc.in_data = 16'h0000; ifc.in_tag = 3'd3; ifc.out_ready = 1'b1;
      step();
      ifc.in_valid = 1'b0;
      chk("single_valid", 32'(ifc.out_valid), 32'd1);
      chk("single_data", 32'(ifc.out_data), 32'h0);
      chk("single_zero", 32'(ifc.out_zero), 32'd1);
      chk("single_neg", 32'(ifc.out_neg), 32'd0);
      chk("single_tag", 32'(ifc.out_tag), 32'd3);
      step();
      chk("single_drained", 32'(ifc.out_valid), 32'd0);

      // Backpressure fills both entries; third offer is held off
      ifc.out_ready = 1'b0;
      ifc.in_valid = 1'b1; ifc.in_data = 16'h8001; ifc.in_tag = 3'd1;
      step();
      ifc.in_data = 16'h00F0; ifc.in_tag = 3'd2;
      step();
      chk("bp_occupancy", 32'(occupancy), 32'd2);
      chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      ifc.in_data = 16'h1234; ifc.in_tag = 3'd5;
      step();
      step();
      chk("bp_held_occ", 32'(occupancy), 32'd2);
      chk("bp_head_data", 32'(ifc.out_data), 32'h8001);
      chk("bp_head_neg", 32'(ifc.out_neg), 32'd1);
      chk("bp_head_tag", 32'(ifc.out_tag), 32'd1);
      ifc.out_ready = 1'b1;
      step();
      chk("bp_second_data", 32'(ifc.out_data), 32'h00F0);
      chk("bp_second_neg", 32'(ifc.out_neg), 32'd0);
      chk("bp_second_occ", 32'(occupancy), 32'd1);
      step();
      ifc.in_valid = 1'b0;
      chk("bp_third_data", 32'(ifc.out_data), 32'h1234);
      chk("bp_third_tag", 32'(ifc.out_tag), 32'd5);
      step();
      chk("bp_empty", 32'(occupancy), 32'd0);

      // Streaming: 100 back-to-back results at full rate
      e0 = n_exit;
      for (int i = 0; i < 100; i++) begin
         ifc.in_valid = 1'b1;
         ifc.in_data  = 16'(i * 16'h0301) ^ 16'h5A00;
         ifc.in_tag   = 3'(i);
         step();
         chk("stream_in_ready", 32'(ifc.in_ready), 32'd1);
      end
      ifc.in_valid = 1'b0;
      step();
      step();
      chk("stream_exits", 32'(n_exit - e0), 32'd100);

      // Flush while full with a same-cycle offer
      ifc.out_ready = 1'b0;
      ifc.in_valid = 1'b1; ifc.in_data = 16'h0A0A; ifc.in_tag = 3'd4;
      step();
      ifc.in_data = 16'h0B0B; ifc.in_tag = 3'd6;
      step();
      chk("fl_full", 32'(occupancy), 32'd2);
      ifc.in_data = 16'hBEEF; ifc.in_tag = 3'd7; flush = 1'b1;
      step();
      flush = 1'b0; ifc.in_valid = 1'b0;
      chk("fl_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("fl_occupancy", 32'(occupancy), 32'd0);
      chk("fl_in_ready", 32'(ifc.in_ready), 32'd1);
      ifc.out_ready = 1'b1;
      repeat (3) step();
      chk("fl_no_ghost", 32'(ifc.out_valid), 32'd0);

      // Flush in ONE with an input that would otherwise be accepted
      ifc.out_ready = 1'b0;
      ifc.in_valid = 1'b1; ifc.in_data = 16'h0C0C; ifc.in_tag = 3'd2;
      step();
      ifc.in_data = 16'h0D0D; flush = 1'b1;
      step();
      flush = 1'b0; ifc.in_valid = 1'b0;
      chk("fl1_occupancy", 32'(occupancy), 32'd0);
      step();
      chk("fl1_no_ghost", 32'(ifc.out_valid), 32'd0);

      // Asynchronous reset while full
      ifc.in_valid = 1'b1; ifc.in_data = 16'h7FFF; ifc.in_tag = 3'd1;
      step();
      ifc.in_data = 16'hFFFF; ifc.in_tag = 3'd2;
      step();
      ifc.in_valid = 1'b0;
      chk("rst_mid_full", 32'(occupancy), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_mid_in_ready", 32'(ifc.in_ready), 32'd1);
      chk("rst_mid_occ", 32'(occupancy), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      chk("rst_mid_after", 32'(occupancy), 32'd0);

      // Random traffic with upstream hold-until-accepted and occasional flush
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         acc = ifc.in_valid && ifc.in_ready;
         @(posedge clk);
         #1;
         if (!ifc.in_valid || acc || flush) begin
            ifc.in_valid = 1'($urandom_range(0, 1));
            ifc.in_data  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            ifc.in_tag   = 3'($urandom);
         end
         ifc.out_ready = 1'($urandom_range(0, 1));
         flush = ($urandom_range(0, 31) == 0);
      end
      flush = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
      for (int i = 0; i < 10 && ifc.out_valid; i++) step();
      chk("rand_drained", 32'(ifc.out_valid), 32'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
